// File: rtl/letter_scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling letter display controller.
// Letter codes follow the shared seven-segment letter decoder's code table.
package ldf_pkg;

  localparam int CODE_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // HOLD lies outside the 5-bit code space, so it is held one bit wider.
  localparam logic [CODE_W:0] CODE_SPACE = 6'd0;
  localparam logic [CODE_W:0] CODE_HOLD  = 6'd32;

  localparam logic [CODE_W-1:0] CODE_A = 5'd1;
  localparam logic [CODE_W-1:0] CODE_B = 5'd2;
  localparam logic [CODE_W-1:0] CODE_C = 5'd3;
  localparam logic [CODE_W-1:0] CODE_D = 5'd4;
  localparam logic [CODE_W-1:0] CODE_E = 5'd5;
  localparam logic [CODE_W-1:0] CODE_F = 5'd6;
  localparam logic [CODE_W-1:0] CODE_G = 5'd7;
  localparam logic [CODE_W-1:0] CODE_H = 5'd8;
  localparam logic [CODE_W-1:0] CODE_I = 5'd9;
  localparam logic [CODE_W-1:0] CODE_L = 5'd10;
  localparam logic [CODE_W-1:0] CODE_N = 5'd11;
  localparam logic [CODE_W-1:0] CODE_O = 5'd12;
  localparam logic [CODE_W-1:0] CODE_P = 5'd13;
  localparam logic [CODE_W-1:0] CODE_R = 5'd14;
  localparam logic [CODE_W-1:0] CODE_S = 5'd15;
  localparam logic [CODE_W-1:0] CODE_T = 5'd16;
  localparam logic [CODE_W-1:0] CODE_U = 5'd17;
  localparam logic [CODE_W-1:0] CODE_Y = 5'd18;

  function automatic logic is_blank(input logic [CODE_W-1:0] code);
    return ({1'b0, code} == CODE_SPACE) || ({1'b0, code} == CODE_HOLD);
  endfunction

endpackage

// File: rtl/letter_scroll_ctrl_if.sv
// Message-source and display-side signals of the scroll controller.
// master = message source / display consumer, slave = controller.
interface letter_scroll_ctrl_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MSG_DEPTH = 16
) ();
  import ldf_pkg::*;

  logic                             wr_en;
  logic [CODE_W-1:0]                wr_data;
  logic                             wr_ready;
  logic                             clear;
  logic                             start;
  logic                             stop;
  logic [CODE_W-1:0]                code_out;
  logic [DIGITS-1:0]                an;
  logic                             busy;
  logic [$clog2(MSG_DEPTH+1)-1:0]   msg_len;
  logic                             wrap;

  modport master (
    output wr_en, wr_data, clear, start, stop,
    input  wr_ready, code_out, an, busy, msg_len, wrap
  );

  modport slave (
    input  wr_en, wr_data, clear, start, stop,
    output wr_ready, code_out, an, busy, msg_len, wrap
  );

endinterface

// File: rtl/letter_scroll_ctrl_tick_gen.sv
// Single-cycle enable every DIV cycles; clr holds the count at 0 (sync).
// First tick arrives DIV cycles after clr drops; DIV = 1 ticks every cycle.
module tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned        CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CNT_LAST);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/letter_scroll_ctrl.sv
// Buffers letter codes and time-shares one decoder across DIGITS, scrolling long messages.
// code_out/an are registered (one cycle behind slot/ptr); writes accepted only in IDLE when not full.
module letter_scroll_ctrl
  import ldf_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MSG_DEPTH   = 16,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SCROLL_DIV  = 50000000
) (
  input logic                  clk,
  input logic                  rst_n,
  letter_scroll_ctrl_if.slave  bus
);

  localparam int unsigned       LEN_W     = $clog2(MSG_DEPTH + 1);
  localparam int unsigned       SUM_W     = LEN_W + 1;
  localparam int unsigned       ADDR_W    = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int unsigned       SLOT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(MSG_DEPTH);
  localparam logic [LEN_W-1:0]  DIGITS_L  = LEN_W'(DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_LEFT   = DIGITS'(1) << (DIGITS - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    ptr_q, ptr_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                wrap_q, wrap_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   msg_buf_q [MSG_DEPTH];

  logic                wr_ready;
  logic                buf_we;
  logic                timers_clr;
  logic                refresh_tick;
  logic                scroll_tick;
  logic [SUM_W-1:0]    idx_sum;
  logic [CODE_W-1:0]   rd_code;

  // Both timers sit at zero outside RUN so every entry restarts them.
  assign timers_clr = (state_q != RUN);

  tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timers_clr),
    .tick  (refresh_tick)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timers_clr),
    .tick  (scroll_tick)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    slot_d   = slot_q;
    wrap_d   = 1'b0;
    wr_ready = (state_q == IDLE) && (len_q < DEPTH_L);
    buf_we   = bus.wr_en && wr_ready && !bus.clear;

    if (buf_we) begin
      len_d = len_q + 1'b1;
    end

    if (state_q == RUN) begin
      if (refresh_tick) begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end
      if (scroll_tick && (len_q > DIGITS_L)) begin
        if (ptr_q == len_q - 1'b1) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end

    // start sees len_d so a write in the same cycle can make the message non-empty.
    if (bus.clear) begin
      state_d = IDLE;
      len_d   = '0;
      ptr_d   = '0;
      slot_d  = '0;
      wrap_d  = 1'b0;
    end else if (bus.stop) begin
      state_d = IDLE;
      ptr_d   = '0;
      slot_d  = '0;
      wrap_d  = 1'b0;
    end else if (bus.start && (state_q == IDLE) && (len_d != '0)) begin
      state_d = RUN;
      ptr_d   = '0;
      slot_d  = '0;
    end
  end

  // ptr < len and slot < DIGITS, so a single conditional subtract wraps the index.
  always_comb begin
    idx_sum = {1'b0, ptr_q} + SUM_W'(slot_q);
    if (idx_sum >= {1'b0, len_q}) begin
      idx_sum = idx_sum - {1'b0, len_q};
    end
    rd_code = msg_buf_q[idx_sum[ADDR_W-1:0]];
    an_d    = '1;
    code_d  = '0;
    if ((state_q == RUN) && (LEN_W'(slot_q) < len_q) && !is_blank(rd_code)) begin
      an_d   = ~(AN_LEFT >> slot_q);
      code_d = rd_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      slot_q  <= '0;
      wrap_q  <= 1'b0;
      an_q    <= '1;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      msg_buf_q[len_q[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.busy     = (state_q == RUN);
  assign bus.msg_len  = len_q;
  assign bus.wrap     = wrap_q;
  assign bus.an       = an_q;
  assign bus.code_out = code_q;

endmodule

// File: tb/tb_letter_scroll_ctrl.sv
// Bench for letter_scroll_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against an elapsed-time model of the scrolling display.
module tb_letter_scroll_ctrl;

  localparam int D     = 4;
  localparam int DEPTH = 16;
  localparam int RDIV  = 4;
  localparam int SDIV  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  letter_scroll_ctrl_if #(.DIGITS(D), .MSG_DEPTH(DEPTH)) bus ();

  letter_scroll_ctrl #(
    .DIGITS      (D),
    .MSG_DEPTH   (DEPTH),
    .REFRESH_DIV (RDIV),
    .SCROLL_DIV  (SDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: display derived from cycles elapsed since the RUN entry edge.
  logic [4:0] m_msg [DEPTH];
  int         m_len   = 0;
  bit         m_run   = 0;
  int         m_t     = 0;
  bit         m_valid = 0;
  logic [3:0] e_an    = 4'hF;
  logic [4:0] e_code  = 5'd0;
  bit         e_wrap  = 0;

  always @(posedge clk) begin
    logic [3:0] n_an;
    logic [4:0] n_code;
    bit         n_wrap;
    int         slot, ptr, idx;
    n_an   = 4'hF;
    n_code = 5'd0;
    n_wrap = 0;
    if (m_run) begin
      slot = (m_t / RDIV) % D;
      ptr  = (m_len > D) ? (m_t / SDIV) % m_len : 0;
      if (slot < m_len) begin
        idx = (ptr + slot) % m_len;
        if (m_msg[idx] != 5'd0) begin
          n_an   = ~(4'b0001 << (D - 1 - slot));
          n_code = m_msg[idx];
        end
      end
    end
    if (!rst_n) begin
      m_valid = 1;
      m_len   = 0;
      m_run   = 0;
      m_t     = 0;
      n_an    = 4'hF;
      n_code  = 5'd0;
    end else begin
      if (!bus.clear && !m_run && bus.wr_en && m_len < DEPTH) begin
        m_msg[m_len] = bus.wr_data;
        m_len++;
      end
      if (bus.clear) begin
        m_len = 0;
        m_run = 0;
      end else if (bus.stop) begin
        m_run = 0;
      end else if (m_run) begin
        m_t++;
        if (m_len > D && (m_t % (SDIV * m_len)) == 0) n_wrap = 1;
      end else if (bus.start && m_len > 0) begin
        m_run = 1;
        m_t   = 0;
      end
    end
    e_an   = n_an;
    e_code = n_code;
    e_wrap = n_wrap;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an",       32'(bus.an),       32'(e_an));
      chk("code_out", 32'(bus.code_out), 32'(e_code));
      chk("wrap",     32'(bus.wrap),     32'(e_wrap));
      chk("busy",     32'(bus.busy),     32'(m_run));
      chk("msg_len",  32'(bus.msg_len),  32'(m_len));
      chk("wr_ready", 32'(bus.wr_ready), 32'(!m_run && m_len < DEPTH));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] code);
    bus.wr_en   = 1'b1;
    bus.wr_data = code;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic chk_disp(input string nm, input logic [3:0] an, input logic [4:0] code);
    chk({nm, "_an"},   32'(bus.an),       32'(an));
    chk({nm, "_code"}, 32'(bus.code_out), 32'(code));
  endtask

  initial begin
    int         wraps;
    int         n, cyc;
    logic [5:0] hold6;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 5'd0;
    bus.clear   = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    step();
    step();
    chk("rst_an",       32'(bus.an),       32'hF);
    chk("rst_code",     32'(bus.code_out), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_msg_len",  32'(bus.msg_len),  32'd0);
    chk("rst_wrap",     32'(bus.wrap),     32'd0);
    rst_n = 1'b1;
    step();

    // HELLO: scrolls, wraps once after 5 steps
    write(5'd8); write(5'd5); write(5'd10); write(5'd10); write(5'd12);
    pulse_start();
    wraps = 0;
    for (int j = 1; j <= 330; j++) begin
      step();
      case (j)
        1:   chk_disp("hello_s0", 4'b0111, 5'd8);
        5:   chk_disp("hello_s1", 4'b1011, 5'd5);
        9:   chk_disp("hello_s2", 4'b1101, 5'd10);
        13:  chk_disp("hello_s3", 4'b1110, 5'd10);
        65:  chk_disp("hello_step1", 4'b0111, 5'd5);
        320: chk("hello_wrap_edge", 32'(bus.wrap), 32'd1);
        321: chk_disp("hello_back", 4'b0111, 5'd8);
        default: ;
      endcase
      if (bus.wrap) wraps++;
    end
    chk("hello_wrap_count", 32'(wraps), 32'd1);

    // Reset while running
    rst_n = 1'b0;
    step();
    chk("midrst_an",       32'(bus.an),       32'hF);
    chk("midrst_busy",     32'(bus.busy),     32'd0);
    chk("midrst_msg_len",  32'(bus.msg_len),  32'd0);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Short message: no scroll, slots 2 and 3 blank
    write(5'd1); write(5'd2);
    pulse_start();
    wraps = 0;
    for (int j = 1; j <= 300; j++) begin
      step();
      case (j)
        1:  chk_disp("short_s0", 4'b0111, 5'd1);
        5:  chk_disp("short_s1", 4'b1011, 5'd2);
        9:  chk_disp("short_s2", 4'b1111, 5'd0);
        13: chk_disp("short_s3", 4'b1111, 5'd0);
        default: ;
      endcase
      if (bus.wrap) wraps++;
    end
    chk("short_wrap_count", 32'(wraps), 32'd0);
    pulse_stop();

    // Full buffer, then clear beats start and wr_en
    pulse_clear();
    for (int i = 0; i < DEPTH; i++) write(5'($urandom_range(1, 31)));
    chk("full_msg_len",  32'(bus.msg_len),  32'd16);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 5'd7;
    step();
    bus.wr_en   = 1'b0;
    chk("full_ignored", 32'(bus.msg_len), 32'd16);
    pulse_start();
    repeat (100) step();
    bus.clear   = 1'b1;
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 5'd7;
    step();
    bus.clear   = 1'b0;
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    chk("clr_msg_len", 32'(bus.msg_len), 32'd0);
    chk("clr_busy",    32'(bus.busy),    32'd0);

    // SPACE and HOLD entries blank their digits
    hold6 = 6'd32;
    write(5'd3); write(5'd0); write(hold6[4:0]); write(5'd4);
    pulse_start();
    for (int j = 1; j <= 40; j++) begin
      step();
      case (j)
        1:  chk_disp("space_s0", 4'b0111, 5'd3);
        5:  chk_disp("space_s1", 4'b1111, 5'd0);
        9:  chk_disp("space_s2", 4'b1111, 5'd0);
        13: chk_disp("space_s3", 4'b1110, 5'd4);
        default: ;
      endcase
    end
    pulse_stop();
    repeat (3) step();
    chk("stop_keeps_len", 32'(bus.msg_len), 32'd4);
    pulse_start();
    step();
    chk_disp("resume_s0", 4'b0111, 5'd3);
    pulse_stop();

    // Empty start ignored; write+start together runs
    pulse_clear();
    pulse_start();
    chk("empty_start_busy", 32'(bus.busy), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 5'd9;
    bus.start   = 1'b1;
    step();
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    chk("wrstart_busy",    32'(bus.busy),    32'd1);
    chk("wrstart_msg_len", 32'(bus.msg_len), 32'd1);
    step();
    chk_disp("wrstart_s0", 4'b0111, 5'd9);
    pulse_stop();

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      pulse_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write(5'($urandom_range(0, 31)));
      pulse_start();
      cyc = $urandom_range(100, 1200);
      for (int c = 0; c < cyc; c++) begin
        bus.wr_en   = ($urandom_range(0, 9) == 0);
        bus.wr_data = 5'($urandom_range(0, 31));
        bus.start   = ($urandom_range(0, 19) == 0);
        step();
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      case (r % 3)
        0: pulse_stop();
        1: pulse_clear();
        default: begin
          rst_n = 1'b0;
          step();
          rst_n = 1'b1;
        end
      endcase
      repeat (3) step();
    end

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
